// File: rtl/rstseq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and counter sizing.
package rstseq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_HOLD   = 3'd0,
        S_LOCK   = 3'd1,
        S_REL    = 3'd2,
        S_RUN    = 3'd3,
        S_ASSERT = 3'd4
    } seq_state_e;

    // Largest of four cycle limits.
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Shared counter width; the extra bit leaves headroom so saturation never hides a limit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        return $clog2(max4(a, b, c, d)) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Consecutive-high filter: qual_c is high on the cycle that completes FILTER_LEN
// consecutive high samples of din (and stays high while din stays high).
module lock_filter #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic qual_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive highs; any low sample or a clear restarts the run.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !din) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_W'(FILTER_LEN)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Run-length register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign qual_c = din && !clr && (cnt_q >= CNT_W'(FILTER_LEN - 1));

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: holds all domains in reset until PLL lock is
// qualified, releases them in index order, re-asserts them in reverse order on
// a software request, and drops everything on lock loss.
// Optional macro RSTSEQ_WDOG_EN adds an S_LOCK watchdog and the lock_timeout port.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int unsigned N_DOM        = 3,
    parameter int unsigned HOLD_CYC     = 16,
    parameter int unsigned GAP_CYC      = 8,
    parameter int unsigned LOCK_FILTER  = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 sw_rst_req,
    output logic                 sw_rst_ack,
    output logic [N_DOM-1:0]     dom_rst_n,
    output logic                 all_ready,
    output logic [STATE_W-1:0]   seq_state
`ifdef RSTSEQ_WDOG_EN
    ,
    output logic                 lock_timeout
`endif
);

    localparam int unsigned CNT_W  = cnt_width(HOLD_CYC, GAP_CYC, LOCK_FILTER, LOCK_TIMEOUT);
    localparam int unsigned STEP_W = $clog2(N_DOM + 1);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [N_DOM-1:0]   dom_rst_n_q, dom_rst_n_d;
    logic               all_ready_q, all_ready_d;
    logic               sw_rst_ack_q, sw_rst_ack_d;
    logic               pending_q, pending_d;
    logic               ackdue_q, ackdue_d;
    logic               lock_clr;
    logic               lock_qual_c;
    logic               lock_lost;
`ifdef RSTSEQ_WDOG_EN
    logic [CNT_W-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0]   wd_inc;
    logic               lock_timeout_q, lock_timeout_d;
`endif

    // Low n bits set: the first n domains out of reset.
    function automatic logic [N_DOM-1:0] thermo(input int unsigned n);
        return N_DOM'((32'd1 << n) - 32'd1);
    endfunction

    // Lock qualification only runs while waiting in S_LOCK.
    assign lock_clr = (state_q != S_LOCK);

    lock_filter #(
        .FILTER_LEN (LOCK_FILTER),
        .CNT_W      (CNT_W)
    ) u_lock_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (lock_clr),
        .din    (pll_locked),
        .qual_c (lock_qual_c)
    );

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign lock_lost = !pll_locked &&
                       ((state_q == S_REL) || (state_q == S_RUN) || (state_q == S_ASSERT));
`ifdef RSTSEQ_WDOG_EN
    assign wd_inc    = (&wd_q) ? wd_q : wd_q + CNT_W'(1);
`endif

    // Next-state and registered-output logic; lock loss overrides the orderly sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        dom_rst_n_d  = dom_rst_n_q;
        all_ready_d  = all_ready_q;
        sw_rst_ack_d = 1'b0;
        pending_d    = pending_q | sw_rst_req;
        ackdue_d     = ackdue_q;
`ifdef RSTSEQ_WDOG_EN
        wd_d           = '0;
        lock_timeout_d = lock_timeout_q;
`endif

        if (lock_lost) begin
            state_d     = S_HOLD;
            cnt_d       = '0;
            step_d      = '0;
            dom_rst_n_d = '0;
            all_ready_d = 1'b0;
            if (pending_q || sw_rst_req) begin
                pending_d = 1'b0;
                ackdue_d  = 1'b1;
            end
        end else begin
            case (state_q)
                S_HOLD: begin
                    dom_rst_n_d = '0;
                    all_ready_d = 1'b0;
                    if (cnt_q >= CNT_W'(HOLD_CYC - 1)) begin
                        state_d = S_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_LOCK: begin
                    if (lock_qual_c) begin
                        state_d     = S_REL;
                        cnt_d       = '0;
                        step_d      = STEP_W'(1);
                        dom_rst_n_d = thermo(1);
                    end
`ifdef RSTSEQ_WDOG_EN
                    else if (wd_q >= CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d        = S_HOLD;
                        cnt_d          = '0;
                        lock_timeout_d = 1'b1;
                    end else begin
                        wd_d = wd_inc;
                    end
`endif
                end
                S_REL: begin
                    if (cnt_q >= CNT_W'(GAP_CYC - 1)) begin
                        cnt_d = '0;
                        if (step_q >= STEP_W'(N_DOM)) begin
                            state_d     = S_RUN;
                            step_d      = '0;
                            all_ready_d = 1'b1;
                            if (ackdue_q) begin
                                sw_rst_ack_d = 1'b1;
                                ackdue_d     = 1'b0;
                            end
                        end else begin
                            step_d      = step_q + STEP_W'(1);
                            dom_rst_n_d = thermo(32'(step_q) + 32'd1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_RUN: begin
                    if (pending_q) begin
                        state_d     = S_ASSERT;
                        pending_d   = 1'b0;
                        ackdue_d    = 1'b1;
                        all_ready_d = 1'b0;
                        cnt_d       = '0;
                        step_d      = STEP_W'(1);
                        dom_rst_n_d = thermo(N_DOM - 1);
                    end
                end
                S_ASSERT: begin
                    if (cnt_q >= CNT_W'(GAP_CYC - 1)) begin
                        cnt_d = '0;
                        if (step_q >= STEP_W'(N_DOM)) begin
                            state_d     = S_HOLD;
                            step_d      = '0;
                            dom_rst_n_d = '0;
                        end else begin
                            step_d      = step_q + STEP_W'(1);
                            dom_rst_n_d = thermo(N_DOM - 32'(step_q) - 32'd1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    step_d      = '0;
                    dom_rst_n_d = '0;
                    all_ready_d = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            step_q       <= '0;
            dom_rst_n_q  <= '0;
            all_ready_q  <= 1'b0;
            sw_rst_ack_q <= 1'b0;
            pending_q    <= 1'b0;
            ackdue_q     <= 1'b0;
`ifdef RSTSEQ_WDOG_EN
            wd_q           <= '0;
            lock_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            dom_rst_n_q  <= dom_rst_n_d;
            all_ready_q  <= all_ready_d;
            sw_rst_ack_q <= sw_rst_ack_d;
            pending_q    <= pending_d;
            ackdue_q     <= ackdue_d;
`ifdef RSTSEQ_WDOG_EN
            wd_q           <= wd_d;
            lock_timeout_q <= lock_timeout_d;
`endif
        end
    end

    assign dom_rst_n  = dom_rst_n_q;
    assign all_ready  = all_ready_q;
    assign sw_rst_ack = sw_rst_ack_q;
    assign seq_state  = state_q;
`ifdef RSTSEQ_WDOG_EN
    assign lock_timeout = lock_timeout_q;
`endif

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Multi-domain reset controller for single-clock FPGA designs.
- Holds every downstream reset domain in reset until the PLL reports a stable lock.
- Releases the domains one at a time in index order, with a fixed cycle gap between releases.
- Accepts software re-reset requests and reasserts the domains in reverse order.
- Sits between the board-level reset generator and the per-domain logic; all domains share the one clock.

Parameters:
- N_DOM, 3, number of reset domains (1..8).
- HOLD_CYC, 16, minimum cycles all domains are held in reset before lock qualification starts (>=1).
- GAP_CYC, 8, cycles between successive domain release or assert steps (>=1).
- LOCK_FILTER, 4, consecutive pll_locked=1 cycles required to qualify lock (>=1).
- LOCK_TIMEOUT, 1024, watchdog limit in cycles; used only with RSTSEQ_WDOG_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; synchronous deassertion is provided upstream.
- pll_locked  in  1  raw PLL lock indicator, synchronous to clk.
- sw_rst_req  in  1  one-cycle pulse requesting a full re-sequence.
- sw_rst_ack  out  1  one-cycle pulse on completion of a software-requested sequence.
- dom_rst_n  out  N_DOM  per-domain active-low resets, registered.
- all_ready  out  1  high when every domain has been released.
- seq_state  out  3  current FSM state, for debug.
- lock_timeout  out  1  sticky watchdog flag; exists only with RSTSEQ_WDOG_EN.

Behaviour:
- Reset values, while rst_n=0:
  - dom_rst_n=0, all_ready=0, sw_rst_ack=0, seq_state=S_HOLD.
  - All counters=0, pending=0, lock_timeout=0.
- All outputs are registered; no combinational path from input to output.
- State S_HOLD:
  - All dom_rst_n=0.
  - Count HOLD_CYC cycles, then go to S_LOCK.
- State S_LOCK:
  - Lock counter increments while pll_locked=1 and clears to 0 when pll_locked=0.
  - When the counter reaches LOCK_FILTER, go to S_REL.
- State S_REL:
  - dom_rst_n[0] rises on the entry edge.
  - dom_rst_n[k] rises k*GAP_CYC cycles after entry.
  - GAP_CYC cycles after dom_rst_n[N_DOM-1] rises, go to S_RUN.
- State S_RUN:
  - all_ready=1.
  - Goes to S_ASSERT if pending=1.
- State S_ASSERT:
  - all_ready falls on the entry edge.
  - dom_rst_n[N_DOM-1] falls on the entry edge; dom_rst_n[N_DOM-1-k] falls k*GAP_CYC cycles after entry.
  - GAP_CYC cycles after dom_rst_n[0] falls, go to S_HOLD.
- Released domains never toggle back high out of order. At any time, dom_rst_n is a monotone pattern: low indices are released first.
- Lock loss (pll_locked=0) in S_REL, S_RUN or S_ASSERT:
  - On the next edge, all dom_rst_n=0 and all_ready=0.
  - Go to S_HOLD with counters cleared.
  - Lock loss overrides the orderly sequence.
- Software request handling:
  - sw_rst_req=1 in any state sets pending.
  - pending is cleared on entry to S_ASSERT, or on entry to S_HOLD caused by lock loss.
  - A flag ackdue is set when pending is consumed.
  - On the edge entering S_RUN with ackdue=1, sw_rst_ack pulses for one cycle and ackdue clears.
- Simultaneous events:
  - sw_rst_req together with lock loss: lock loss wins; pending is still consumed and the ack is delivered on the next S_RUN entry.
  - Multiple requests before consumption merge into one sequence and one ack.
- Counter width: $clog2 of the maximum of HOLD_CYC, GAP_CYC, LOCK_FILTER and LOCK_TIMEOUT, plus 1. Counters saturate, never wrap.
- Asserting rst_n mid-sequence immediately returns all outputs to their reset values.

Optional Feature:
RSTSEQ_WDOG_EN
- Defined:
  - A watchdog counts cycles spent in S_LOCK.
  - At LOCK_TIMEOUT, lock_timeout is set (sticky until rst_n) and the FSM returns to S_HOLD to retry.
  - The watchdog counter clears on every S_LOCK entry.
- Undefined:
  - No watchdog logic, and the lock_timeout port is absent.
  - S_LOCK waits indefinitely.

Decomposition:
- Shared package rstseq_pkg holds:
  - State encoding S_HOLD=0, S_LOCK=1, S_REL=2, S_RUN=3, S_ASSERT=4.
  - The 3-bit state width constant.
- One natural sub-module: lock_filter, a consecutive-high counter with a qualified output and a clear input. It is instantiated for pll_locked.

Test Plan:
- Power-up, defaults, pll_locked=1 from cycle 0; timings counted in cycles after rst_n deasserts:
  - S_LOCK entered at cycle 16, S_REL at cycle 20.
  - dom_rst_n = 001 at 20, 011 at 28, 111 at 36.
  - all_ready=1 at 44.
- Lock glitch in S_LOCK: pll_locked low for 1 cycle after 3 qualifying cycles -> filter restarts; S_REL entered 4 cycles after lock returns.
- sw_rst_req pulse in S_RUN:
  - dom_rst_n = 011, 001, 000 at 8-cycle spacing.
  - Full re-sequence follows.
  - One sw_rst_ack pulse on S_RUN re-entry.
- pll_locked drops while dom_rst_n=011 in S_REL -> next edge dom_rst_n=000, all_ready=0, state S_HOLD.
- Two sw_rst_req pulses 3 cycles apart during S_REL -> exactly one S_ASSERT sequence after S_RUN, and exactly one ack.
- With RSTSEQ_WDOG_EN, LOCK_TIMEOUT=32, pll_locked=0 held -> lock_timeout=1 after 32 cycles in S_LOCK, then S_HOLD/S_LOCK retry loop.
